// File: rtl/display_tick_scheduler.sv
// Purpose: single-clock scan/animation strobe generator and multiplexed-display sequencer (IDLE/BLANK/DRIVE).
// Latency: every output is registered; the first anode goes low BLANK_CYCLES+1 cycles after enable rises.
// Backpressure: none, free-running strobes. Optional macro DIGIT_MASK_EN adds a digit_mask input that skips digits.
module display_tick_scheduler #(
    parameter int SCAN_DIV     = 262144,
    parameter int ANIM_DIV     = 8388608,
    parameter int BLANK_CYCLES = 64,
    parameter int N_DIGITS     = 4,
    parameter int DIGIT_W      = 2
) (
    input  logic                clk50Mhz,
    input  logic                reset,
    input  logic                enable,
    input  logic                anim_run,
    input  logic                anim_step,
`ifdef DIGIT_MASK_EN
    input  logic [N_DIGITS-1:0] digit_mask,
`endif
    output logic                scan_tick,
    output logic                anim_tick,
    output logic [DIGIT_W-1:0]  digit_sel,
    output logic [N_DIGITS-1:0] anode,
    output logic [7:0]          frame,
    output logic                blanking
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int ANIM_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int BLK_W  = $clog2(BLANK_CYCLES + 1);

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [ANIM_W-1:0]  ANIM_LAST  = ANIM_W'(ANIM_DIV - 1);
    localparam logic [BLK_W-1:0]   BLK_LAST   = BLK_W'(BLANK_CYCLES - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [ANIM_W-1:0]     anim_cnt_q, anim_cnt_d;
    logic [BLK_W-1:0]      blank_cnt_q, blank_cnt_d;
    logic                  scan_tick_q, scan_tick_d;
    logic                  anim_tick_q, anim_tick_d;
    logic                  step_q, step_d;
    logic [DIGIT_W-1:0]    digit_sel_q, digit_sel_d;
    logic [N_DIGITS-1:0]   anode_q, anode_d;
    logic [7:0]            frame_q, frame_d;
    logic                  blanking_q, blanking_d;
    logic [DIGIT_W-1:0]    digit_next;

    function automatic logic [DIGIT_W-1:0] digit_inc(input logic [DIGIT_W-1:0] d);
        return (d == DIGIT_LAST) ? '0 : d + DIGIT_W'(1);
    endfunction

`ifdef DIGIT_MASK_EN
    // First enabled index strictly after cur (ascending, wrapping); cur itself if nothing is enabled.
    function automatic logic [DIGIT_W-1:0] next_enabled(input logic [DIGIT_W-1:0] cur,
                                                         input logic [N_DIGITS-1:0] mask);
        logic [DIGIT_W-1:0] cand;
        logic [DIGIT_W-1:0] res;
        logic               found;
        cand  = cur;
        res   = cur;
        found = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            cand = digit_inc(cand);
            if (!found && mask[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction
`endif

    // Scan divider: wraps every SCAN_DIV enabled cycles; tick follows the terminal count by one cycle.
    always_comb begin
        scan_cnt_d  = '0;
        scan_tick_d = 1'b0;
        if (enable) begin
            scan_cnt_d  = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + SCAN_W'(1);
            scan_tick_d = (scan_cnt_q == SCAN_LAST);
        end
    end

    // Animation: free-run divider, or one tick per sampled rising edge of anim_step; counter parks at 0 in step mode
    // so a 0->1 change of anim_run always restarts the frame period from zero.
    always_comb begin
        step_d      = anim_step;
        anim_cnt_d  = '0;
        anim_tick_d = 1'b0;
        if (anim_run) begin
            anim_cnt_d  = (anim_cnt_q == ANIM_LAST) ? '0 : anim_cnt_q + ANIM_W'(1);
            anim_tick_d = (anim_cnt_q == ANIM_LAST);
        end else begin
            anim_tick_d = anim_step & ~step_q;
        end
        frame_d = anim_tick_q ? frame_q + 8'd1 : frame_q;
    end

    // Digit advance target used when a DRIVE dwell ends.
    always_comb begin
`ifdef DIGIT_MASK_EN
        digit_next = next_enabled(digit_sel_q, digit_mask);
`else
        digit_next = digit_inc(digit_sel_q);
`endif
    end

    // Display FSM next state; enable=0 wins over everything, including a coincident scan_tick.
    always_comb begin
        state_d     = state_q;
        digit_sel_d = digit_sel_q;
        blank_cnt_d = blank_cnt_q;
        case (state_q)
            S_IDLE: begin
                digit_sel_d = '0;
                blank_cnt_d = '0;
                if (enable) begin
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                if (blank_cnt_q == BLK_LAST) begin
`ifdef DIGIT_MASK_EN
                    // With nothing enabled we park here, anodes dark, until a mask bit appears.
                    if (|digit_mask) begin
                        state_d     = S_DRIVE;
                        blank_cnt_d = '0;
                        if (!digit_mask[digit_sel_q]) begin
                            digit_sel_d = digit_next;
                        end
                    end
`else
                    state_d     = S_DRIVE;
                    blank_cnt_d = '0;
`endif
                end else begin
                    blank_cnt_d = blank_cnt_q + BLK_W'(1);
                end
            end
            S_DRIVE: begin
                // A tick arriving during BLANK is dropped; only DRIVE consumes it.
                if (scan_tick_q) begin
                    state_d     = S_BLANK;
                    digit_sel_d = digit_next;
                    blank_cnt_d = '0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                digit_sel_d = '0;
                blank_cnt_d = '0;
            end
        endcase
        if (!enable) begin
            state_d     = S_IDLE;
            digit_sel_d = '0;
            blank_cnt_d = '0;
        end
    end

    // Output decode from the next state so anode/blanking/digit_sel register in step with the state.
    always_comb begin
        blanking_d = (state_d != S_DRIVE);
        anode_d    = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            anode_d[i] = ~((state_d == S_DRIVE) && (digit_sel_d == DIGIT_W'(i)));
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk50Mhz) begin
        if (reset) begin
            state_q     <= S_IDLE;
            scan_cnt_q  <= '0;
            anim_cnt_q  <= '0;
            blank_cnt_q <= '0;
            scan_tick_q <= 1'b0;
            anim_tick_q <= 1'b0;
            step_q      <= 1'b0;
            digit_sel_q <= '0;
            anode_q     <= '1;
            frame_q     <= '0;
            blanking_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            scan_cnt_q  <= scan_cnt_d;
            anim_cnt_q  <= anim_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            scan_tick_q <= scan_tick_d;
            anim_tick_q <= anim_tick_d;
            step_q      <= step_d;
            digit_sel_q <= digit_sel_d;
            anode_q     <= anode_d;
            frame_q     <= frame_d;
            blanking_q  <= blanking_d;
        end
    end

    assign scan_tick = scan_tick_q;
    assign anim_tick = anim_tick_q;
    assign digit_sel = digit_sel_q;
    assign anode     = anode_q;
    assign frame     = frame_q;
    assign blanking  = blanking_q;

endmodule

// File: tb/tb_display_tick_scheduler.sv
// Purpose: self-checking bench for display_tick_scheduler (default build, no digit mask).
// Latency: outputs sampled 1 time unit after each rising edge and compared to a cycle-count reference.
// Backpressure: not applicable.
module tb_display_tick_scheduler;

    localparam int SCAN_DIV     = 8;
    localparam int ANIM_DIV     = 32;
    localparam int BLANK_CYCLES = 2;
    localparam int N_DIGITS     = 4;
    localparam int DIGIT_W      = 2;

    logic                clk50Mhz = 1'b0;
    logic                reset    = 1'b1;
    logic                enable   = 1'b0;
    logic                anim_run = 1'b0;
    logic                anim_step = 1'b0;
    logic                scan_tick;
    logic                anim_tick;
    logic [DIGIT_W-1:0]  digit_sel;
    logic [N_DIGITS-1:0] anode;
    logic [7:0]          frame;
    logic                blanking;

    always #5 clk50Mhz = ~clk50Mhz;

    display_tick_scheduler #(
        .SCAN_DIV    (SCAN_DIV),
        .ANIM_DIV    (ANIM_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .N_DIGITS    (N_DIGITS),
        .DIGIT_W     (DIGIT_W)
    ) dut (
        .clk50Mhz (clk50Mhz),
        .reset    (reset),
        .enable   (enable),
        .anim_run (anim_run),
        .anim_step(anim_step),
        .scan_tick(scan_tick),
        .anim_tick(anim_tick),
        .digit_sel(digit_sel),
        .anode    (anode),
        .frame    (frame),
        .blanking (blanking)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: run lengths and event counts rather than the design's registers.
    int n_en      = 0;   // consecutive edges with enable=1 since the last reset/disable
    int n_run     = 0;   // consecutive edges with anim_run=1 since the last reset/step mode
    bit m_prev    = 0;   // anim_step as sampled at the previous edge
    bit m_atick   = 0;
    int m_frame   = 0;
    int tick_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic run, input logic stp);
        logic [31:0] exp_anode;
        int          ph;
        int          dig;
        bit          blk;
        bit          stick;
        reset     = r;
        enable    = e;
        anim_run  = run;
        anim_step = stp;
        @(posedge clk50Mhz);
        if (r) begin
            n_en    = 0;
            n_run   = 0;
            m_prev  = 0;
            m_atick = 0;
            m_frame = 0;
        end else begin
            m_frame = (m_frame + int'(m_atick)) % 256;
            n_en    = e ? n_en + 1 : 0;
            if (run) begin
                n_run   = n_run + 1;
                m_atick = (n_run % ANIM_DIV) == 0;
            end else begin
                n_run   = 0;
                m_atick = stp && !m_prev;
            end
            m_prev = stp;
        end
        // Display expectation from the enabled-cycle count: each scan period opens with
        // BLANK_CYCLES dark cycles, then drives digit (period index mod N_DIGITS).
        stick = (n_en > 0) && ((n_en % SCAN_DIV) == 0);
        if (n_en == 0) begin
            blk = 1;
            dig = 0;
        end else begin
            ph  = (n_en - 1) % SCAN_DIV;
            dig = ((n_en - 1) / SCAN_DIV) % N_DIGITS;
            blk = ph < BLANK_CYCLES;
        end
        exp_anode = blk ? 32'hF : (~(32'd1 << dig)) & 32'hF;
        #1;
        chk("scan_tick", 32'(scan_tick), 32'(stick));
        chk("anim_tick", 32'(anim_tick), 32'(m_atick));
        chk("digit_sel", 32'(digit_sel), 32'(dig));
        chk("anode",     32'(anode),     exp_anode);
        chk("frame",     32'(frame),     32'(m_frame));
        chk("blanking",  32'(blanking),  32'(blk));
    endtask

    initial begin
        // Reset, then free scan across a full digit rotation and back to digit 0.
        repeat (3) cycle(1, 0, 0, 0);
        repeat (40) cycle(0, 1, 0, 0);

        // Free-running animation for 100 cycles.
        cycle(1, 0, 0, 0);
        repeat (100) cycle(0, 0, 1, 0);
        chk("frame_after_100", 32'(frame), 32'd3);

        // Three step pulses in step mode.
        cycle(1, 0, 0, 0);
        tick_cnt = 0;
        for (int p = 0; p < 3; p++) begin
            cycle(0, 0, 0, 1); tick_cnt += int'(anim_tick);
            cycle(0, 0, 0, 1); tick_cnt += int'(anim_tick);
            cycle(0, 0, 0, 0); tick_cnt += int'(anim_tick);
        end
        cycle(0, 0, 0, 0); tick_cnt += int'(anim_tick);
        chk("step_tick_count", 32'(tick_cnt), 32'd3);

        // 256 frames via fast stepping: frame wraps back to 0.
        cycle(1, 0, 0, 0);
        for (int p = 0; p < 256; p++) begin
            cycle(0, 0, 0, 1);
            cycle(0, 0, 0, 0);
        end
        cycle(0, 0, 0, 0);
        chk("frame_wrap", 32'(frame), 32'd0);

        // Drop enable on the scan_tick cycle while driving digit 2.
        cycle(1, 0, 0, 0);
        repeat (24) cycle(0, 1, 0, 0);
        chk("tick_at_digit2", 32'(scan_tick), 32'd1);
        chk("digit2_driven",  32'(digit_sel), 32'd2);
        cycle(0, 0, 0, 0);
        chk("disable_anode", 32'(anode),     32'hF);
        chk("disable_digit", 32'(digit_sel), 32'd0);
        chk("disable_blank", 32'(blanking),  32'd1);

        // Reset while driving digit 1 with frame=5, all other inputs active.
        cycle(1, 0, 0, 0);
        for (int p = 0; p < 5; p++) begin
            cycle(0, 1, 0, 1);
            cycle(0, 1, 0, 0);
        end
        repeat (2) cycle(0, 1, 0, 0);
        chk("pre_reset_frame", 32'(frame),     32'd5);
        chk("pre_reset_digit", 32'(digit_sel), 32'd1);
        chk("pre_reset_drive", 32'(blanking),  32'd0);
        cycle(1, 1, 1, 1);
        chk("rst_scan_tick", 32'(scan_tick), 32'd0);
        chk("rst_anim_tick", 32'(anim_tick), 32'd0);
        chk("rst_digit",     32'(digit_sel), 32'd0);
        chk("rst_anode",     32'(anode),     32'hF);
        chk("rst_frame",     32'(frame),     32'd0);
        chk("rst_blanking",  32'(blanking),  32'd1);

        // Randomized segments of enable / run / step activity with occasional resets.
        for (int s = 0; s < 60; s++) begin
            int  len;
            bit  e;
            bit  run;
            bit  r;
            len = int'($urandom_range(1, 50));
            e   = $urandom_range(0, 4) != 0;
            run = $urandom_range(0, 1) != 0;
            r   = $urandom_range(0, 9) == 0;
            for (int k = 0; k < len; k++) begin
                cycle(r && (k == 0), e, run, $urandom_range(0, 1) != 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
